// File: rtl/tile_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_ram_arbiter
// Brief    : Arbitrates one single-port tile RAM between video fetch and CPU.
//            Video has priority, and the CPU is guaranteed a slot after
//            STARVE_MAX blocked cycles.
// Revision : 1.0  initial release
// ============================================================================
module tile_ram_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int STARVE_MAX = 7
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic              o_vid_valid,
   output logic [DATA_W-1:0] o_vid_data,
   output logic              o_vid_miss,
   input  logic              i_cpu_valid,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ready,
   output logic              o_cpu_rvalid,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_miss_clr,
   output logic [7:0]        o_miss_cnt,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_din,
   output logic              o_ram_we,
   input  logic [DATA_W-1:0] i_ram_dout
);

   localparam int c_starve_w = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   owner_t                r_owner;
   logic [c_starve_w-1:0] r_starve;
   logic [7:0]            r_miss_cnt;

   logic w_vid_grant;
   logic w_cpu_grant;
   logic w_vid_miss;

   // Grants are qualified by reset so the RAM is never written while held in reset.
   assign w_vid_grant = i_rst_n & i_vid_req & (r_starve < c_starve_max);
   assign w_cpu_grant = i_rst_n & ~w_vid_grant & i_cpu_valid;
   assign w_vid_miss  = i_rst_n & i_vid_req & (r_starve == c_starve_max);

   assign o_cpu_ready  = w_cpu_grant;
   assign o_vid_miss   = w_vid_miss;
   assign o_ram_addr   = w_vid_grant ? i_vid_addr : i_cpu_addr;
   assign o_ram_din    = i_cpu_wdata;
   assign o_ram_we     = w_cpu_grant & i_cpu_we;

   assign o_vid_valid  = (r_owner == OWN_VID);
   assign o_cpu_rvalid = (r_owner == OWN_CPU);
   assign o_vid_data   = i_ram_dout;
   assign o_cpu_rdata  = i_ram_dout;
   assign o_miss_cnt   = r_miss_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner    <= OWN_NONE;
         r_starve   <= '0;
         r_miss_cnt <= 8'd0;
      end else begin
         if (w_vid_grant)
            r_owner <= OWN_VID;
         else if (w_cpu_grant && !i_cpu_we)
            r_owner <= OWN_CPU;
         else
            r_owner <= OWN_NONE;

         if (w_cpu_grant || !i_cpu_valid)
            r_starve <= '0;
         else if (r_starve < c_starve_max)
            r_starve <= r_starve + c_starve_w'(1);

         if (i_miss_clr)
            r_miss_cnt <= 8'd0;
         else if (w_vid_miss && (r_miss_cnt != 8'hFF))
            r_miss_cnt <= r_miss_cnt + 8'd1;
      end
   end

endmodule
`default_nettype wire

// File: doc/tile_ram_arbiter.md
TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the tile RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the tile RAM data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 7, meaning the count of consecutive CPU-blocked cycles before the CPU is forced a slot.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 The block SHALL have port i_clk  in  1  system clock; all state updates on the rising edge.
REQ-006 The block SHALL have port i_rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port i_vid_req  in  1  video fetch read request for this cycle.
REQ-008 The block SHALL have port i_vid_addr  in  ADDR_W  video fetch address.
REQ-009 The block SHALL have port o_vid_valid  out  1  video read data valid.
REQ-010 The block SHALL have port o_vid_data  out  DATA_W  video read data.
REQ-011 The block SHALL have port o_vid_miss  out  1  one-cycle pulse: video request dropped.
REQ-012 The block SHALL have port i_cpu_valid  in  1  CPU access request.
REQ-013 The block SHALL have port i_cpu_we  in  1  CPU access is a write (1) or a read (0).
REQ-014 The block SHALL have port i_cpu_addr  in  ADDR_W  CPU access address.
REQ-015 The block SHALL have port i_cpu_wdata  in  DATA_W  CPU write data.
REQ-016 The block SHALL have port o_cpu_ready  out  1  CPU access accepted this cycle.
REQ-017 The block SHALL have port o_cpu_rvalid  out  1  CPU read data valid.
REQ-018 The block SHALL have port o_cpu_rdata  out  DATA_W  CPU read data.
REQ-019 The block SHALL have port i_miss_clr  in  1  synchronous clear of the miss counter.
REQ-020 The block SHALL have port o_miss_cnt  out  8  saturating count of dropped video requests.
REQ-021 The block SHALL have port o_ram_addr  out  ADDR_W  single-port RAM address.
REQ-022 The block SHALL have port o_ram_din  out  DATA_W  RAM write data.
REQ-023 The block SHALL have port o_ram_we  out  1  RAM write enable.
REQ-024 The block SHALL have port i_ram_dout  in  DATA_W  RAM registered read data, 1-cycle latency.

Function
REQ-025 Grant SHALL be combinational per cycle, in priority order:
- video, if i_vid_req and starve_cnt < STARVE_MAX;
- else CPU, if i_cpu_valid;
- else idle.
REQ-026 o_cpu_ready SHALL equal the CPU grant; a CPU transfer occurs only when i_cpu_valid and o_cpu_ready are both high.
REQ-027 RAM drive SHALL follow the grant:
- video grant: o_ram_addr=i_vid_addr, o_ram_we=0;
- CPU grant: o_ram_addr=i_cpu_addr, o_ram_we=i_cpu_we, o_ram_din=i_cpu_wdata;
- idle: o_ram_we=0.
REQ-028 A 2-bit read-owner register SHALL have states NONE, VID and CPU; it loads VID on video grant, CPU on CPU read grant, and NONE otherwise (including CPU write grant).
REQ-029 o_vid_valid SHALL be 1 exactly when the owner is VID; o_cpu_rvalid SHALL be 1 exactly when the owner is CPU; both data outputs SHALL equal i_ram_dout; latency is request cycle N -> valid cycle N+1.
REQ-030 starve_cnt (width ceil(log2(STARVE_MAX+1))) SHALL behave as follows:
- increments when i_cpu_valid and not granted;
- saturates at STARVE_MAX;
- clears on CPU grant or when i_cpu_valid=0.
REQ-031 When starve_cnt==STARVE_MAX and i_vid_req=1, the CPU SHALL be granted (if i_cpu_valid), the video request dropped, and o_vid_miss pulsed in that cycle.
REQ-032 o_miss_cnt SHALL increment on each o_vid_miss, saturating at 255; i_miss_clr SHALL zero it and take priority over a simultaneous increment.
REQ-033 A CPU write followed next cycle by a read of the same address from either requester SHALL return the new data.
REQ-034 Video data SHALL never be attributed to the CPU, nor CPU data to the video requester; at most one read SHALL be in flight.

Reset
REQ-035 While i_rst_n=0, outputs SHALL be: owner NONE, starve_cnt=0, o_miss_cnt=0, o_vid_valid=0, o_cpu_rvalid=0, o_vid_miss=0, o_ram_we=0.
REQ-036 Reset asserted with a read in flight SHALL discard that read; no valid SHALL appear after release.
REQ-037 The first grant after release SHALL follow REQ-025 on the first rising edge after release.

Verification
REQ-038 Scenario: CPU write addr 0x12 data 0xBEEF, i_vid_req=0 -> o_cpu_ready=1, o_ram_we=1, no rvalid next cycle; CPU read 0x12 -> o_cpu_rvalid=1 with 0xBEEF one cycle later.
REQ-039 Scenario: i_vid_req and i_cpu_valid both high, starve_cnt=0 -> video granted, o_cpu_ready=0, o_vid_valid=1 next cycle with RAM contents at i_vid_addr.
REQ-040 Scenario: i_vid_req held high, CPU read pending -> CPU blocked 7 cycles, granted on cycle 8 with o_vid_miss=1 and o_miss_cnt=1; starve_cnt=0 afterwards.
REQ-041 Scenario: 260 forced misses -> o_miss_cnt=255; i_miss_clr asserted in the same cycle as a miss -> o_miss_cnt=0.
REQ-042 Scenario: CPU read granted, reset asserted before the next edge -> o_cpu_rvalid stays 0 through and after reset.
REQ-043 Scenario: CPU write 0x0001 to addr 0x00, then video read of 0x00 next cycle -> o_vid_data=0x0001.
